// File: rtl/exec_sequencer.sv
// Instruction execution sequencer: injects one received instruction into a
// processor running on a gated divided clock, then triggers a regfile dump.
module exec_sequencer #(
  parameter int unsigned EXEC_CYCLES   = 10,
  parameter int unsigned INJECT_CYCLES = 2,
  parameter logic [31:0] NOOP          = 32'h13000000
) (
  input  logic        clk12,
  input  logic        rstn,
  input  logic        instruction_rcv,
  input  logic [31:0] instruction_in,
  input  logic        tx_ready,
  output logic        clk_proc,
  output logic [31:0] inst_out,
  output logic        send_regfile,
  output logic        busy,
  output logic        pending,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SEND  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] EXEC_LAST  = 8'(EXEC_CYCLES - 1);
  localparam logic [7:0] INJECT_LIM = 8'(INJECT_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        clk6_q, clk6_d;
  logic [31:0] active_q, active_d;
  logic [31:0] buf_q, buf_d;
  logic        pending_q, pending_d;
  logic [7:0]  drop_q, drop_d;

  // State and datapath registers
  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      clk6_q    <= 1'b0;
      active_q  <= NOOP;
      buf_q     <= NOOP;
      pending_q <= 1'b0;
      drop_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk6_q    <= clk6_d;
      active_q  <= active_d;
      buf_q     <= buf_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  // Next-state, counter and holding-buffer logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clk6_d    = ~clk6_q;
    active_d  = active_q;
    buf_d     = buf_q;
    pending_d = pending_q;
    drop_d    = drop_q;

    case (state_q)
      ST_IDLE: begin
        // The buffered word has priority; a simultaneous strobe refills the buffer.
        if (pending_q) begin
          active_d = buf_q;
          cnt_d    = 8'd0;
          state_d  = ST_EXEC;
          if (instruction_rcv) begin
            buf_d = instruction_in;
          end else begin
            pending_d = 1'b0;
          end
        end else if (instruction_rcv) begin
          active_d = instruction_in;
          cnt_d    = 8'd0;
          state_d  = ST_EXEC;
        end else begin
          cnt_d = 8'd0;
        end
      end
      ST_EXEC: begin
        if (cnt_q == EXEC_LAST) begin
          cnt_d   = 8'd0;
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SEND: begin
        cnt_d   = 8'd0;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // cnt_q marks that the mandatory second drain cycle has been reached
        if ((cnt_q != 8'd0) && tx_ready) begin
          cnt_d   = 8'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = 8'd1;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = ST_IDLE;
      end
    endcase

    if ((state_q != ST_IDLE) && instruction_rcv) begin
      if (!pending_q) begin
        buf_d     = instruction_in;
        pending_d = 1'b1;
      end else if (drop_q != 8'd255) begin
        drop_d = drop_q + 8'd1;
      end else begin
        drop_d = drop_q;
      end
    end else begin
      drop_d = drop_q;
    end
  end

  // Outputs decode only registered state, so reset forces them immediately
  assign clk_proc     = (state_q == ST_EXEC) ? clk6_q : 1'b1;
  assign inst_out     = ((state_q == ST_EXEC) && (cnt_q < INJECT_LIM)) ? active_q : NOOP;
  assign send_regfile = (state_q == ST_SEND);
  assign busy         = (state_q != ST_IDLE);
  assign pending      = pending_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: a per-job reference model predicts each
// executed word and the per-cycle outputs; a negedge monitor compares.
module tb_exec_sequencer;

  localparam int          E    = 10;
  localparam int          INJ  = 2;
  localparam logic [31:0] NOOP = 32'h13000000;

  logic        clk12;
  logic        rstn;
  logic        instruction_rcv;
  logic [31:0] instruction_in;
  logic        tx_ready;
  logic        clk_proc;
  logic [31:0] inst_out;
  logic        send_regfile;
  logic        busy;
  logic        pending;
  logic [7:0]  drop_cnt;

  exec_sequencer #(
    .EXEC_CYCLES  (E),
    .INJECT_CYCLES(INJ),
    .NOOP         (NOOP)
  ) dut (
    .clk12          (clk12),
    .rstn           (rstn),
    .instruction_rcv(instruction_rcv),
    .instruction_in (instruction_in),
    .tx_ready       (tx_ready),
    .clk_proc       (clk_proc),
    .inst_out       (inst_out),
    .send_regfile   (send_regfile),
    .busy           (busy),
    .pending        (pending),
    .drop_cnt       (drop_cnt)
  );

  initial clk12 = 1'b0;
  always #5 clk12 = ~clk12;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a job is "k cycles since it started"; k<E executes,
  // k==E is the dump pulse, later cycles drain until tx_ready after two.
  logic [31:0] exp_q[$];
  logic        m_clk6;
  logic        m_job;
  int          m_k;
  logic [31:0] m_word;
  logic        m_pend;
  logic [31:0] m_buf;
  int          m_drops;

  always @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      m_clk6  <= 1'b0;
      m_job   <= 1'b0;
      m_k     <= 0;
      m_word  <= NOOP;
      m_pend  <= 1'b0;
      m_buf   <= NOOP;
      m_drops <= 0;
    end else begin
      m_clk6 <= ~m_clk6;
      if (!m_job) begin
        if (m_pend) begin
          m_job  <= 1'b1;
          m_k    <= 0;
          m_word <= m_buf;
          exp_q.push_back(m_buf);
          if (instruction_rcv) m_buf <= instruction_in;
          else m_pend <= 1'b0;
        end else if (instruction_rcv) begin
          m_job  <= 1'b1;
          m_k    <= 0;
          m_word <= instruction_in;
          exp_q.push_back(instruction_in);
        end
      end else begin
        if (instruction_rcv) begin
          if (!m_pend) begin
            m_buf  <= instruction_in;
            m_pend <= 1'b1;
          end else if (m_drops < 255) begin
            m_drops <= m_drops + 1;
          end
        end
        if (m_k >= E + 2 && tx_ready) m_job <= 1'b0;
        else m_k <= m_k + 1;
      end
    end
  end

  // Monitor: pops the expected word when a job starts, checks outputs each cycle
  logic prev_busy = 1'b0;
  always @(negedge clk12) begin
    logic        in_exec;
    logic [31:0] e_inst;
    in_exec = m_job && (m_k < E);
    e_inst  = (in_exec && m_k < INJ) ? m_word : NOOP;
    if (busy && !prev_busy) begin
      if (exp_q.size() == 0) chk("unexpected_job", inst_out, NOOP);
      else chk("exec_word", inst_out, exp_q.pop_front());
    end
    prev_busy <= busy;
    chk("busy", {31'd0, busy}, {31'd0, m_job});
    chk("inst_out", inst_out, e_inst);
    chk("clk_proc", {31'd0, clk_proc}, {31'd0, in_exec ? m_clk6 : 1'b1});
    chk("send_regfile", {31'd0, send_regfile}, {31'd0, (m_job && m_k == E)});
    chk("pending", {31'd0, pending}, {31'd0, m_pend});
    chk("drop_cnt", {24'd0, drop_cnt}, 32'(m_drops));
  end

  task automatic step(input logic r, input logic [31:0] w, input logic t);
    instruction_rcv = r;
    instruction_in  = w;
    tx_ready        = t;
    @(negedge clk12);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((m_job || m_pend) && n < 500) begin
      step(1'b0, 32'd0, 1'b1);
      n++;
    end
    chk(name, {31'd0, (n >= 500)}, 32'd0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == NOOP) w = w ^ 32'd1;
    return w;
  endfunction

  initial begin
    int nb, ns, ni, n;
    rstn = 1'b0;
    instruction_rcv = 1'b0;
    instruction_in = 32'd0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk12);
    chk("reset_clk_proc", {31'd0, clk_proc}, 32'd1);
    chk("reset_inst_out", inst_out, NOOP);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;
    step(1'b0, 32'd0, 1'b1);

    // Single instruction: 10 EXEC + SEND + 2 DRAIN busy cycles, 2 injected
    step(1'b1, 32'h00500093, 1'b1);
    nb = 0; ns = 0; ni = 0;
    for (int i = 0; i < 20; i++) begin
      nb += int'(busy);
      ns += int'(send_regfile);
      ni += int'(inst_out == 32'h00500093);
      step(1'b0, 32'd0, 1'b1);
    end
    chk("single_busy_cycles", 32'(nb), 32'd13);
    chk("single_send_pulses", 32'(ns), 32'd1);
    chk("single_inject_cycles", 32'(ni), 32'd2);

    // Second strobe during EXEC is buffered, not dropped
    step(1'b1, 32'h11111111, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    step(1'b1, 32'h22222222, 1'b1);
    chk("buffer_pending", {31'd0, pending}, 32'd1);
    chk("buffer_no_drop", {24'd0, drop_cnt}, 32'd0);
    wait_idle("idle_after_buffer");

    // Three strobes during one EXEC: one buffered, two dropped
    step(1'b1, 32'h33333333, 1'b1);
    step(1'b1, 32'h44444444, 1'b1);
    step(1'b1, 32'h55555555, 1'b1);
    step(1'b1, 32'h66666666, 1'b1);
    chk("three_strobes_drops", {24'd0, drop_cnt}, 32'd2);

    // Strobe on the IDLE cycle right after DRAIN while a word is buffered
    n = 0;
    while (m_job && n < 100) begin
      step(1'b0, 32'd0, 1'b1);
      n++;
    end
    chk("drain_exit_timeout", {31'd0, (n >= 100)}, 32'd0);
    step(1'b1, 32'h77777777, 1'b1);
    chk("refill_pending", {31'd0, pending}, 32'd1);
    chk("refill_no_drop", {24'd0, drop_cnt}, 32'd2);
    wait_idle("idle_after_refill");

    // Held tx_ready low: saturating drops and a long DRAIN
    step(1'b1, 32'h88888888, 1'b0);
    for (int i = 0; i < 305; i++) step(1'b1, rand_word(), 1'b0);
    chk("drop_saturate", {24'd0, drop_cnt}, 32'd255);
    chk("drain_hold_busy", {31'd0, busy}, 32'd1);
    chk("drain_hold_clk", {31'd0, clk_proc}, 32'd1);
    step(1'b0, 32'd0, 1'b1);
    wait_idle("idle_after_saturate");

    // Reset at EXEC counter 5 acts without a clock edge
    step(1'b1, 32'h99999999, 1'b1);
    repeat (5) step(1'b0, 32'd0, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("async_clk_proc", {31'd0, clk_proc}, 32'd1);
    chk("async_inst_out", inst_out, NOOP);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    repeat (3) @(negedge clk12);
    rstn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 32'd0, 1'b1);
      chk("no_send_after_reset", {31'd0, send_regfile}, 32'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(5) == 0), rand_word(), ($urandom_range(9) < 7));
    end
    wait_idle("idle_after_random");
    step(1'b0, 32'd0, 1'b1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
